frac_divisor: RTL and testbench
===============================

# frac_divisor

Fractional clock divider that derives `clk_frac` from the 100 MHz system clock with an average division ratio of DIV_INT + FRAC_NUM/FRAC_DEN (default 7.6, about 13.16 MHz).
- Each output period is either DIV_INT or DIV_INT+1 input cycles long.
- The choice between the two is made by a first-order accumulator, so the long and short periods are spread evenly instead of being grouped together.
- The block is a clock-generation leaf. `clk_frac` is a registered signal intended as a low-rate timing or strobe source; it is not a glitch-free clock-tree root.

## Interface
- DIV_INT, default 7: integer part of the ratio. Must be ≥ 2.
- FRAC_NUM, default 6: numerator of the fractional part. Must satisfy 0 ≤ FRAC_NUM < FRAC_DEN.
- FRAC_DEN, default 10: denominator of the fractional part. Must be ≥ 1.
- clk, input, 1: sole clock. All logic updates on the rising edge.
- rstn, input, 1: reset, asynchronous and active-low.
- clk_frac, output, 1: divided output, driven directly from a flop.
- Illegal parameter values must cause an elaboration-time error.

## Operation
- Internal state:
  - period counter `cnt`, width clog2(DIV_INT+1);
  - current period length `per`, either DIV_INT or DIV_INT+1;
  - accumulator `acc`, width clog2(FRAC_DEN)+1;
  - `run` flag.
- Reset (rstn=0, asynchronous): cnt=0, acc=0, per=DIV_INT, run=0, clk_frac=0.
- Period start happens on a rising edge when run=0 or cnt==per-1:
  - run←1, cnt←0, clk_frac←1;
  - if acc+FRAC_NUM ≥ FRAC_DEN: per←DIV_INT+1 and acc←acc+FRAC_NUM−FRAC_DEN;
  - otherwise: per←DIV_INT and acc←acc+FRAC_NUM.
- Any other rising edge:
  - cnt←cnt+1;
  - clk_frac←(cnt+1 < floor(per/2)).
- High phase is floor(per/2) cycles; low phase is the rest of the period.
  - Period of 7: 3 high, 4 low.
  - Period of 8: 4 high, 4 low.
- acc always stays in the range [0, FRAC_DEN−1].
- Over any FRAC_DEN consecutive periods:
  - exactly FRAC_NUM periods are DIV_INT+1 long;
  - the total length is DIV_INT·FRAC_DEN + FRAC_NUM input cycles.
- FRAC_NUM=0 gives a pure integer divide-by-DIV_INT.
- Default period sequence is 7,8,7,8,8, repeating every 38 cycles. The accumulator value after each period start is 6,2,8,4,0.

## Timing
- No latency from any input other than reset.
- The first rising edge after rstn deasserts starts period 0; clk_frac goes 1 on that edge.
- Reset asserted mid-period: clk_frac, cnt and acc clear immediately. After release, the sequence restarts from period 0; the partial pattern is not resumed.
- With a 10 ns clk and rstn released at 11 ns, the first edge is at 15 ns.
- Default clk_frac edges:
  - rise 15, fall 45;
  - rise 85, fall 125;
  - rise 165, fall 195;
  - rise 235, fall 275;
  - rise 315, fall 355;
  - rise 395, then the pattern repeats with a 380 ns period.
- clk_frac is a single registered bit: no combinational path to the output and no glitches.

## Test plan
- Default parameters, rstn released at 11 ns:
  - clk_frac rising edges occur at 15, 85, 165, 235, 315, 395 ns;
  - falling edges occur at 45, 125, 195, 275, 355 ns.
- Long run to 10 µs: between any two rising edges exactly 10 periods apart, exactly 76 clk cycles elapse; the count of 8-cycle periods is 6.
- Reset asserted at 200 ns for 30 ns:
  - clk_frac is 0 within the same timestep as rstn falling;
  - after release, the first period is 7 cycles and the full pattern restarts.
- FRAC_NUM=0, DIV_INT=4: clk_frac is a steady 2-high/2-low square wave, period 40 ns.
- DIV_INT=2, FRAC_NUM=1, FRAC_DEN=2: periods alternate 2,3. High time is 1 cycle in each; 5 cycles per pair.
- rstn held low for 1 µs: clk_frac stays 0 throughout and no internal counter moves.

Source files
------------

// File: rtl/frac_divisor.sv
// -----------------------------------------------------------------------------
// frac_divisor
//
// Fractional clock divider. Produces clk_frac from clk with an average
// division ratio of DIV_INT + FRAC_NUM/FRAC_DEN. Each output period is
// either DIV_INT or DIV_INT+1 input cycles long. A first-order accumulator
// picks the long periods so they are spread evenly rather than bunched.
// The high phase of each period is floor(period/2) cycles.
//
// clk_frac is a registered strobe/timing source, not a clock-tree root.
//
// Parameters:
//   DIV_INT  - integer part of the ratio (>= 2)
//   FRAC_NUM - fractional numerator (0 <= FRAC_NUM < FRAC_DEN)
//   FRAC_DEN - fractional denominator (>= 1)
//
// Ports:
//   clk      - input,  sole clock, rising-edge active
//   rstn     - input,  asynchronous active-low reset
//   clk_frac - output, divided clock, driven directly from a flop
// -----------------------------------------------------------------------------
module frac_divisor #(
  parameter int DIV_INT  = 7,
  parameter int FRAC_NUM = 6,
  parameter int FRAC_DEN = 10
) (
  input  logic clk,
  input  logic rstn,
  output logic clk_frac
);

  if (DIV_INT < 2) begin : g_bad_div_int
    $error("frac_divisor: DIV_INT must be >= 2");
  end
  if (FRAC_DEN < 1) begin : g_bad_frac_den
    $error("frac_divisor: FRAC_DEN must be >= 1");
  end
  if ((FRAC_NUM < 0) || (FRAC_NUM >= FRAC_DEN)) begin : g_bad_frac_num
    $error("frac_divisor: FRAC_NUM must satisfy 0 <= FRAC_NUM < FRAC_DEN");
  end

  // cnt only ever reaches per-1 <= DIV_INT; per itself needs room for DIV_INT+1.
  localparam int CW = $clog2(DIV_INT + 1);
  localparam int PW = $clog2(DIV_INT + 2);
  localparam int AW = $clog2(FRAC_DEN) + 1;

  localparam logic [PW-1:0] PER_SHORT = PW'(DIV_INT);
  localparam logic [PW-1:0] PER_LONG  = PW'(DIV_INT + 1);
  localparam logic [AW-1:0] NUM_A     = AW'(FRAC_NUM);
  localparam logic [AW-1:0] DEN_A     = AW'(FRAC_DEN);

  logic [CW-1:0] cnt;
  logic [PW-1:0] per;
  logic [AW-1:0] acc;
  logic          run;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] per_m1;
  logic [CW-1:0] half;
  logic [AW-1:0] acc_sum;
  logic          take_long;
  logic          start;

  // acc <= FRAC_DEN-1 and FRAC_NUM <= FRAC_DEN-1, so the sum is at most
  // 2*FRAC_DEN-2, which always fits in AW bits without wrapping.
  always_comb begin
    cnt_inc   = cnt + CW'(1);
    per_m1    = CW'(per - PW'(1));
    half      = CW'(per >> 1);
    acc_sum   = acc + NUM_A;
    take_long = (acc_sum >= DEN_A);
    start     = !run || (cnt == per_m1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      per      <= PER_SHORT;
      acc      <= '0;
      run      <= 1'b0;
      clk_frac <= 1'b0;
    end else if (start) begin
      run      <= 1'b1;
      cnt      <= '0;
      clk_frac <= 1'b1;
      if (take_long) begin
        per <= PER_LONG;
        acc <= acc_sum - DEN_A;
      end else begin
        per <= PER_SHORT;
        acc <= acc_sum;
      end
    end else begin
      cnt      <= cnt_inc;
      clk_frac <= (cnt_inc < half);
    end
  end

endmodule

// File: tb/tb_frac_divisor.sv
// -----------------------------------------------------------------------------
// tb_frac_divisor
//
// Drives three frac_divisor instances (default 7.6, pure divide-by-4, and
// 2 + 1/2) from one clock and one reset. Every cycle each output is compared
// with a reference model that derives period lengths from the closed form
// floor((k+1)*NUM/DEN) - floor(k*NUM/DEN). Directed edge times, long-run
// averages and randomized reset assertions are checked on top of that.
// -----------------------------------------------------------------------------
module tb_frac_divisor;

  logic clk;
  logic rstn;
  logic frac_a;
  logic frac_b;
  logic frac_c;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  int ra[$];
  int fa[$];
  int rb[$];
  int rc[$];
  logic pa, pb, pc;

  frac_divisor u_dut_a (
    .clk      (clk),
    .rstn     (rstn),
    .clk_frac (frac_a)
  );

  frac_divisor #(
    .DIV_INT  (4),
    .FRAC_NUM (0),
    .FRAC_DEN (10)
  ) u_dut_b (
    .clk      (clk),
    .rstn     (rstn),
    .clk_frac (frac_b)
  );

  frac_divisor #(
    .DIV_INT  (2),
    .FRAC_NUM (1),
    .FRAC_DEN (2)
  ) u_dut_c (
    .clk      (clk),
    .rstn     (rstn),
    .clk_frac (frac_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected clk_frac after the n-th rising edge since reset release.
  function automatic logic model_out(input int idx, input int di, input int fn, input int fd);
    int k;
    int base;
    int len;
    k    = 0;
    base = 0;
    while (1) begin
      len = di + ((k + 1) * fn / fd) - (k * fn / fd);
      if (idx < base + len) return ((idx - base) < (len / 2));
      base = base + len;
      k    = k + 1;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at cycle %0d", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    int t;
    @(negedge clk);
    t = int'($time) - 5;
    chk_bit("dut_a cycle", frac_a, model_out(n, 7, 6, 10));
    chk_bit("dut_b cycle", frac_b, model_out(n, 4, 0, 10));
    chk_bit("dut_c cycle", frac_c, model_out(n, 2, 1, 2));
    if (!pa && frac_a === 1'b1) ra.push_back(t);
    if (pa && frac_a === 1'b0) fa.push_back(t);
    if (!pb && frac_b === 1'b1) rb.push_back(t);
    if (!pc && frac_c === 1'b1) rc.push_back(t);
    pa = (frac_a === 1'b1);
    pb = (frac_b === 1'b1);
    pc = (frac_c === 1'b1);
    n++;
  endtask

  // Called right after step(), i.e. at a falling clk edge. Asserts reset
  // 'off' time units later, holds it across 'hold' falling edges, and
  // releases one unit after the last of them.
  task automatic do_reset(input int off, input int hold);
    #(off);
    rstn = 1'b0;
    #1;
    chk_bit("reset immediate a", frac_a, 1'b0);
    chk_bit("reset immediate b", frac_b, 1'b0);
    chk_bit("reset immediate c", frac_c, 1'b0);
    repeat (hold) begin
      @(negedge clk);
      chk_bit("reset hold a", frac_a, 1'b0);
      chk_bit("reset hold b", frac_b, 1'b0);
      chk_bit("reset hold c", frac_c, 1'b0);
    end
    #1;
    rstn = 1'b1;
    n    = 0;
    pa   = 1'b0;
    pb   = 1'b0;
    pc   = 1'b0;
    ra.delete();
    fa.delete();
    rb.delete();
    rc.delete();
  endtask

  initial begin
    int exp_rise[6];
    int exp_fall[5];
    int longs;
    int gap;
    int run_len;
    int off;
    int hold;

    exp_rise = '{15, 85, 165, 235, 315, 395};
    exp_fall = '{45, 125, 195, 275, 355};
    pa = 1'b0;
    pb = 1'b0;
    pc = 1'b0;

    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk_bit("reset state a", frac_a, 1'b0);
    chk_bit("reset state b", frac_b, 1'b0);
    chk_bit("reset state c", frac_c, 1'b0);
    #8 rstn = 1'b1;

    // Free run to about 10 us.
    while (n < 1000) step();

    for (int i = 0; i < 6; i++) chk($sformatf("rise %0d time", i), ra[i], exp_rise[i]);
    for (int i = 0; i < 5; i++) chk($sformatf("fall %0d time", i), fa[i], exp_fall[i]);

    for (int i = 0; i + 10 < ra.size(); i++) begin
      chk("ten periods span", ra[i+10] - ra[i], 760);
      longs = 0;
      for (int j = i; j < i + 10; j++) if (ra[j+1] - ra[j] == 80) longs++;
      chk("long periods per ten", longs, 6);
    end

    for (int i = 0; i + 1 < rb.size(); i++) chk("int div period", rb[i+1] - rb[i], 40);

    for (int i = 0; i + 1 < rc.size(); i++) begin
      gap = rc[i+1] - rc[i];
      chk("alternating 2/3 period", gap, (i % 2 == 0) ? 20 : 30);
    end

    // Mid-period reset for 30 time units, then the pattern must restart.
    do_reset(1, 3);
    repeat (60) step();
    chk("restart first period", ra[1] - ra[0], 70);
    chk("restart second period", ra[2] - ra[1], 80);
    chk("restart first high time", fa[0] - ra[0], 30);

    // Randomized reset placement and durations.
    repeat (8) begin
      run_len = $urandom_range(5, 120);
      off     = $urandom_range(1, 8);
      hold    = $urandom_range(1, 6);
      repeat (run_len) step();
      do_reset(off, hold);
    end
    repeat (50) step();

    // Reset held for 1 us; nothing may move, then a clean restart.
    do_reset(1, 100);
    repeat (80) step();
    chk("long reset first rise", ra[0] - ra[0] + (ra.size() > 0 ? 1 : 0), 1);
    chk("long reset first period", ra[1] - ra[0], 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
